fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: a PC generator with credit-based request flow
// control, an in-order response queue toward decode, and redirect/flush handling.
module fetch_queue #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            PCSrcM,
   input  logic [XLEN-1:0] PCBranchM,
   output logic            IMemReqValid,
   output logic [XLEN-1:0] IMemReqAddr,
   input  logic            IMemReqReady,
   input  logic            IMemRespValid,
   input  logic [XLEN-1:0] IMemRespData,
   output logic            InstrValidD,
   input  logic            InstrReadyD,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] respPc_q, respPc_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [CNTW-1:0] inflight_q, inflight_d;
   logic [CNTW-1:0] drop_q, drop_d;
   logic [PTRW-1:0] wrPtr_q, wrPtr_d;
   logic [PTRW-1:0] rdPtr_q, rdPtr_d;
   logic [XLEN-1:0] pcMem_q    [DEPTH];
   logic [XLEN-1:0] instrMem_q [DEPTH];

   logic [CNTW:0] occupancy;
   logic          reqFire;
   logic          respAccept;
   logic          respDrop;
   logic          push;
   logic          pop;

   // Entries queued plus requests outstanding bound the queue, so a push never overflows
   assign occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
   assign IMemReqValid = ~RST & ~PCSrcM & (occupancy < (CNTW + 1)'(DEPTH));
   assign IMemReqAddr  = pc_q;
   assign reqFire      = IMemReqValid & IMemReqReady;

   // Responses with nothing outstanding are spurious and ignored entirely
   assign respAccept = IMemRespValid & (inflight_q != '0);
   assign respDrop   = respAccept & (drop_q != '0);
   assign push       = respAccept & (drop_q == '0) & ~PCSrcM;

   assign InstrValidD = ~RST & ~PCSrcM & (count_q != '0);
   assign pop         = InstrValidD & InstrReadyD;
   assign InstrD      = instrMem_q[rdPtr_q];
   assign PCD         = pcMem_q[rdPtr_q];
   assign PCPlus4D    = PCD + XLEN'(4);

   always_comb begin
      pc_d       = pc_q;
      respPc_d   = respPc_q;
      count_d    = count_q;
      drop_d     = drop_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      inflight_d = inflight_q + CNTW'(reqFire) - CNTW'(respAccept);
      if (PCSrcM) begin
         // Everything still outstanding belongs to the wrong path and must be discarded
         pc_d     = PCBranchM;
         respPc_d = PCBranchM;
         count_d  = '0;
         wrPtr_d  = '0;
         rdPtr_d  = '0;
         drop_d   = inflight_q - CNTW'(respAccept);
      end else begin
         if (reqFire) pc_d = pc_q + XLEN'(4);
         if (push) begin
            respPc_d = respPc_q + XLEN'(4);
            wrPtr_d  = wrPtr_q + PTRW'(1);
         end
         if (pop) rdPtr_d = rdPtr_q + PTRW'(1);
         if (respDrop) drop_d = drop_q - CNTW'(1);
         count_d = count_q + CNTW'(push) - CNTW'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q       <= RESET_PC;
         respPc_q   <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         respPc_q   <= respPc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         pcMem_q[wrPtr_q]    <= respPc_q;
         instrMem_q[wrPtr_q] <= IMemRespData;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order memory model, a decode-side
// scoreboard, a per-cycle vector table for credit flow, and redirect/reset sequences.
module tb_fetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcSrc;
   logic [31:0] pcBranch;
   logic        reqValid;
   logic [31:0] reqAddr;
   logic        memReady;
   logic        respValid;
   logic [31:0] respData;
   logic        instrValid;
   logic        decReady;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcPlus4D;

   bit          memHold;
   logic [31:0] memQ [$];
   logic [31:0] expQ [$];
   logic [31:0] expPc;
   int          nCompared;
   int          nMismatched;
   int          popCount;
   int          hsCount;
   logic [31:0] lastPopPc;
   bit          sawWrap;
   logic [31:0] wrapPlus4;

   typedef struct {
      bit rst;
      bit memReady;
      bit decReady;
      bit expReqValid;
      bit expInstrValid;
   } vec_t;
   vec_t vecs [12];

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
      .CLK          (clk),
      .RST          (rst),
      .PCSrcM       (pcSrc),
      .PCBranchM    (pcBranch),
      .IMemReqValid (reqValid),
      .IMemReqAddr  (reqAddr),
      .IMemReqReady (memReady),
      .IMemRespValid(respValid),
      .IMemRespData (respData),
      .InstrValidD  (instrValid),
      .InstrReadyD  (decReady),
      .InstrD       (instrD),
      .PCD          (pcD),
      .PCPlus4D     (pcPlus4D)
   );

   // Instruction word the memory model returns for a given address
   function automatic logic [31:0] memData(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One clock cycle: drive the memory response, sample at negedge, update models
   task automatic applyStimulus(input bit chk, input bit expReqV, input bit expIv);
      logic [31:0] e;
      respValid = !memHold && (memQ.size() > 0);
      respData  = respValid ? memData(memQ[0]) : 32'h0;
      @(negedge clk);
      if (chk) begin
         checkOutput("req_valid", 32'(reqValid), 32'(expReqV));
         checkOutput("instr_valid", 32'(instrValid), 32'(expIv));
      end
      if (instrValid && decReady) begin
         popCount++;
         lastPopPc = pcD;
         if (pcD == 32'hFFFF_FFFC) begin
            sawWrap   = 1'b1;
            wrapPlus4 = pcPlus4D;
         end
         if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_pop: got PCD 0x%08h, expected no instruction", pcD);
         end else begin
            e = expQ.pop_front();
            checkOutput("pcd", pcD, e);
            checkOutput("instr", instrD, memData(e));
            checkOutput("pcplus4", pcPlus4D, e + 32'd4);
         end
      end
      if (reqValid && memReady) begin
         hsCount++;
         checkOutput("req_addr", reqAddr, expPc);
         memQ.push_back(reqAddr);
         if (!rst && !pcSrc) expQ.push_back(reqAddr);
         expPc = expPc + 32'd4;
      end
      if (respValid) void'(memQ.pop_front());
      if (rst) begin
         expQ.delete();
         expPc = RESET_PC;
      end else if (pcSrc) begin
         expQ.delete();
         expPc = pcBranch;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst      = 1'b1;
      pcSrc    = 1'b0;
      memReady = 1'b0;
      decReady = 1'b0;
      memHold  = 1'b0;
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      memQ.delete();
   endtask

   // Run until the next decode pop and compare its PC, bounded by a cycle budget
   task automatic waitPop(input string name, input logic [31:0] expPcVal);
      int start;
      int n;
      start = popCount;
      n     = 0;
      while (popCount == start && n < 30) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (popCount == start) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s: got no pop within 30 cycles, expected PCD 0x%08h", name, expPcVal);
      end else begin
         checkOutput(name, lastPopPc, expPcVal);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int start;
      nCompared   = 0;
      nMismatched = 0;
      popCount    = 0;
      hsCount     = 0;
      sawWrap     = 1'b0;
      wrapPlus4   = 32'hDEAD_BEEF;
      lastPopPc   = 32'h0;
      expPc       = RESET_PC;
      rst         = 1'b1;
      pcSrc       = 1'b0;
      pcBranch    = 32'h0;
      memReady    = 1'b0;
      decReady    = 1'b0;
      memHold     = 1'b0;
      respValid   = 1'b0;
      respData    = 32'h0;

      // Credit flow with decode stalled, then released: rst, memReady, decReady, reqV, instrV
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      @(posedge clk);
      #1;
      doReset();
      hsCount = 0;
      for (int i = 0; i < 12; i++) begin
         rst      = vecs[i].rst;
         memReady = vecs[i].memReady;
         decReady = vecs[i].decReady;
         applyStimulus(1'b1, vecs[i].expReqValid, vecs[i].expInstrValid);
         if (i == 7) checkOutput("credit_handshakes", 32'(hsCount), 32'd4);
      end

      // Steady streaming: one instruction per cycle
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      start = popCount;
      repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stream_rate", 32'(popCount - start), 32'd16);

      // Redirect with two queued and two in flight
      doReset();
      memReady = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      memReady = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1);
      memReady = 1'b1;
      memHold  = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      pcSrc    = 1'b1;
      pcBranch = 32'h0000_0100;
      applyStimulus(1'b1, 1'b0, 1'b0);
      pcSrc    = 1'b0;
      memHold  = 1'b0;
      decReady = 1'b1;
      waitPop("redirect_first_pcd", 32'h0000_0100);

      // Redirect coinciding with a response and an attempted pop
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
      memHold = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      memHold  = 1'b0;
      pcSrc    = 1'b1;
      pcBranch = 32'h0000_0200;
      applyStimulus(1'b1, 1'b0, 1'b0);
      pcSrc = 1'b0;
      waitPop("redirect_resp_pop_pcd", 32'h0000_0200);

      // Address wrap at the top of the address space
      pcSrc    = 1'b1;
      pcBranch = 32'hFFFF_FFF0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      pcSrc = 1'b0;
      repeat (15) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("wrap_seen", 32'(sawWrap), 32'd1);
      checkOutput("wrap_pcplus4", wrapPlus4, 32'h0000_0000);

      // Reset with three requests in flight, stale responses returned afterwards
      doReset();
      memReady = 1'b1;
      memHold  = 1'b1;
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      rst      = 1'b0;
      memReady = 1'b0;
      memHold  = 1'b0;
      decReady = 1'b1;
      checkOutput("post_reset_addr", reqAddr, RESET_PC);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
      memReady = 1'b1;
      waitPop("post_reset_first_pcd", RESET_PC);

      // Drain: every fetched instruction must reach decode
      memReady = 1'b0;
      repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
